// File: rtl/flags_stack.sv
`default_nettype none
// ============================================================================
//  Module      : flags_stack
//  Description : WIDTH-bit condition flag register with per-bit masked update
//                and a DEPTH-entry LIFO save/restore stack for call/interrupt
//                context, plus sticky overflow/underflow error reporting.
//  Revision    : 1.0 - initial release
// ============================================================================
module flags_stack #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic             update_en,
  input  logic [WIDTH-1:0] flag_input,
  input  logic [WIDTH-1:0] update_mask,
  input  logic             push,
  input  logic             pop,
  input  logic             clear_err,
  output logic [WIDTH-1:0] flag_reg,
  output logic [WIDTH-1:0] stack_top,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             overflow_err,
  output logic             underflow_err
);

  // Address width of the stack storage; a single-entry stack still needs one bit.
  localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_ONE   = CW'(1);

  logic [WIDTH-1:0] r_stack [DEPTH];
  logic [WIDTH-1:0] r_flag;
  logic [CW-1:0]    r_count;
  logic             r_ovf;
  logic             r_unf;

  logic [WIDTH-1:0] w_flag_next;
  logic [CW-1:0]    w_count_next;
  logic             w_ovf_next;
  logic             w_unf_next;
  logic             w_full;
  logic             w_empty;
  logic [AW-1:0]    w_top_idx;
  logic [AW-1:0]    w_push_idx;
  logic [WIDTH-1:0] w_top;
  logic [WIDTH-1:0] w_masked;
  logic             w_do_push;
  logic             w_do_pop;
  logic             w_do_xchg;
  logic             w_ovf_evt;
  logic             w_unf_evt;
  logic             w_stack_we;
  logic [AW-1:0]    w_stack_widx;

  assign w_full     = (r_count == C_DEPTH);
  assign w_empty    = (r_count == '0);
  // The occupancy count doubles as the write pointer; top entry sits one below.
  assign w_push_idx = AW'(r_count);
  assign w_top_idx  = AW'(r_count - C_ONE);
  // Masking while empty keeps stale RAM contents (never reset) invisible.
  assign w_top      = w_empty ? '0 : r_stack[w_top_idx];
  assign w_masked   = (r_flag & ~update_mask) | (flag_input & update_mask);

  // Decode the stack operation for this cycle; nothing happens while run is low.
  always_comb begin
    w_do_push = 1'b0;
    w_do_pop  = 1'b0;
    w_do_xchg = 1'b0;
    w_ovf_evt = 1'b0;
    w_unf_evt = 1'b0;
    if (run) begin
      if (push && !pop) begin
        w_do_push = !w_full;
        w_ovf_evt = w_full;
      end else if (pop && !push) begin
        w_do_pop  = !w_empty;
        w_unf_evt = w_empty;
      end else if (push && pop) begin
        // An exchange never overflows: the stack depth is unchanged.
        w_do_xchg = !w_empty;
        w_unf_evt = w_empty;
      end
    end
  end

  // Next-state for flags, occupancy and sticky error bits.
  always_comb begin
    w_flag_next  = r_flag;
    w_count_next = r_count;
    w_ovf_next   = r_ovf;
    w_unf_next   = r_unf;
    w_stack_we   = 1'b0;
    w_stack_widx = w_push_idx;
    if (run) begin
      // A successful restore takes priority over the ALU update.
      if (w_do_pop || w_do_xchg) begin
        w_flag_next = w_top;
      end else if (update_en) begin
        w_flag_next = w_masked;
      end

      if (w_do_push) begin
        w_count_next = r_count + C_ONE;
        w_stack_we   = 1'b1;
        w_stack_widx = w_push_idx;
      end else if (w_do_pop) begin
        w_count_next = r_count - C_ONE;
      end else if (w_do_xchg) begin
        w_stack_we   = 1'b1;
        w_stack_widx = w_top_idx;
      end

      // A fresh error event beats a simultaneous clear for that bit.
      if (w_ovf_evt) begin
        w_ovf_next = 1'b1;
      end else if (clear_err) begin
        w_ovf_next = 1'b0;
      end
      if (w_unf_evt) begin
        w_unf_next = 1'b1;
      end else if (clear_err) begin
        w_unf_next = 1'b0;
      end
    end
  end

  // Control state with asynchronous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_flag  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_flag  <= w_flag_next;
      r_count <= w_count_next;
      r_ovf   <= w_ovf_next;
      r_unf   <= w_unf_next;
    end
  end

  // Stack storage; the write always saves the pre-update flag value.
  always_ff @(posedge clock) begin
    if (w_stack_we) begin
      r_stack[w_stack_widx] <= r_flag;
    end
  end

  assign flag_reg      = r_flag;
  assign stack_top     = w_top;
  assign count         = r_count;
  assign full          = w_full;
  assign empty         = w_empty;
  assign overflow_err  = r_ovf;
  assign underflow_err = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_flags_stack.sv
`default_nettype none
// ============================================================================
//  Module      : tb_flags_stack
//  Description : Self-checking bench for flags_stack; drives a WIDTH=4/DEPTH=4
//                and a WIDTH=8/DEPTH=1 instance with the same stimulus and
//                compares both against a behavioural array model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_flags_stack;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic       update_en = 1'b0;
  logic [7:0] flag_input = '0;
  logic [7:0] update_mask = '0;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic       clear_err = 1'b0;

  logic [3:0] a_flag, a_top;
  logic [2:0] a_count;
  logic       a_full, a_empty, a_ovf, a_unf;
  logic [7:0] b_flag, b_top;
  logic [0:0] b_count;
  logic       b_full, b_empty, b_ovf, b_unf;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state, index 0 = small-width deep stack, 1 = wide single entry.
  logic [7:0] m_f   [2];
  logic [7:0] m_stk [2][16];
  int         m_cnt [2];
  logic       m_o   [2];
  logic       m_u   [2];

  flags_stack #(.WIDTH(4), .DEPTH(4)) dut_a (
    .clock(clock), .reset(reset), .run(run), .update_en(update_en),
    .flag_input(flag_input[3:0]), .update_mask(update_mask[3:0]),
    .push(push), .pop(pop), .clear_err(clear_err),
    .flag_reg(a_flag), .stack_top(a_top), .count(a_count),
    .full(a_full), .empty(a_empty), .overflow_err(a_ovf), .underflow_err(a_unf)
  );

  flags_stack #(.WIDTH(8), .DEPTH(1)) dut_b (
    .clock(clock), .reset(reset), .run(run), .update_en(update_en),
    .flag_input(flag_input), .update_mask(update_mask),
    .push(push), .pop(pop), .clear_err(clear_err),
    .flag_reg(b_flag), .stack_top(b_top), .count(b_count),
    .full(b_full), .empty(b_empty), .overflow_err(b_ovf), .underflow_err(b_unf)
  );

  always #5 clock = ~clock;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_f[k] = '0; m_cnt[k] = 0; m_o[k] = 1'b0; m_u[k] = 1'b0;
    end
  endtask

  // One clock of the documented behaviour, using the inputs present at the edge.
  task automatic model_step(input int k);
    int         depth;
    logic [7:0] wm, nf;
    logic       restored, eo, eu;
    depth = (k == 0) ? 4 : 1;
    wm    = (k == 0) ? 8'h0f : 8'hff;
    if (!run) return;
    nf = m_f[k]; restored = 1'b0; eo = 1'b0; eu = 1'b0;
    if (push && !pop) begin
      if (m_cnt[k] < depth) begin
        m_stk[k][m_cnt[k]] = m_f[k];
        m_cnt[k]++;
      end else eo = 1'b1;
    end else if (pop && !push) begin
      if (m_cnt[k] > 0) begin
        m_cnt[k]--;
        nf = m_stk[k][m_cnt[k]];
        restored = 1'b1;
      end else eu = 1'b1;
    end else if (push && pop) begin
      if (m_cnt[k] > 0) begin
        nf = m_stk[k][m_cnt[k]-1];
        m_stk[k][m_cnt[k]-1] = m_f[k];
        restored = 1'b1;
      end else eu = 1'b1;
    end
    if (!restored && update_en)
      nf = ((m_f[k] & ~update_mask) | (flag_input & update_mask)) & wm;
    m_f[k] = nf;
    m_o[k] = eo ? 1'b1 : (clear_err ? 1'b0 : m_o[k]);
    m_u[k] = eu ? 1'b1 : (clear_err ? 1'b0 : m_u[k]);
  endtask

  task automatic compare_all();
    logic [7:0] ta, tb;
    ta = (m_cnt[0] > 0) ? m_stk[0][m_cnt[0]-1] : 8'h00;
    tb = (m_cnt[1] > 0) ? m_stk[1][m_cnt[1]-1] : 8'h00;
    check_value("a_flag",  32'(a_flag),  32'(m_f[0][3:0]));
    check_value("a_top",   32'(a_top),   32'(ta[3:0]));
    check_value("a_count", 32'(a_count), 32'(m_cnt[0]));
    check_value("a_full",  32'(a_full),  32'(m_cnt[0] == 4));
    check_value("a_empty", 32'(a_empty), 32'(m_cnt[0] == 0));
    check_value("a_ovf",   32'(a_ovf),   32'(m_o[0]));
    check_value("a_unf",   32'(a_unf),   32'(m_u[0]));
    check_value("b_flag",  32'(b_flag),  32'(m_f[1]));
    check_value("b_top",   32'(b_top),   32'(tb));
    check_value("b_count", 32'(b_count), 32'(m_cnt[1]));
    check_value("b_full",  32'(b_full),  32'(m_cnt[1] == 1));
    check_value("b_empty", 32'(b_empty), 32'(m_cnt[1] == 0));
    check_value("b_ovf",   32'(b_ovf),   32'(m_o[1]));
    check_value("b_unf",   32'(b_unf),   32'(m_u[1]));
  endtask

  // Apply inputs away from the edge, clock once, update the model, check #1 later.
  task automatic step(input logic r, input logic ue, input logic [7:0] fi, input logic [7:0] m,
                      input logic ps, input logic pp, input logic ce);
    run = r; update_en = ue; flag_input = fi; update_mask = m;
    push = ps; pop = pp; clear_err = ce;
    @(posedge clock);
    model_step(0);
    model_step(1);
    #1;
    compare_all();
  endtask

  // Reset asserted between edges must clear state without waiting for a clock.
  task automatic async_reset();
    #2 reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    #1 reset = 1'b0;
  endtask

  initial begin
    logic [3:0] pops [4];
    pops = '{4'h7, 4'h5, 4'h3, 4'h9};

    // Power-on reset
    repeat (2) @(posedge clock);
    #1;
    model_reset();
    compare_all();
    reset = 1'b0;

    // Masked update
    step(1, 1, 8'h0a, 8'h0f, 0, 0, 0);
    check_value("tp1_full_write", 32'(a_flag), 32'h a);
    step(1, 1, 8'h05, 8'h03, 0, 0, 0);
    check_value("tp1_masked", 32'(a_flag), 32'h9);

    // Push keeps pre-update value, pop restores and ignores update
    step(1, 1, 8'h06, 8'h0f, 1, 0, 0);
    check_value("tp2_top", 32'(a_top), 32'h9);
    check_value("tp2_flag", 32'(a_flag), 32'h6);
    check_value("tp2_b_full", 32'(b_full), 32'h1);
    step(1, 1, 8'h0f, 8'h0f, 0, 1, 0);
    check_value("tp2_restore", 32'(a_flag), 32'h9);
    check_value("tp2_empty_top", 32'(a_top), 32'h0);

    // Fill, overflow, LIFO drain, underflow
    step(1, 1, 8'h03, 8'h0f, 1, 0, 0);
    step(1, 1, 8'h05, 8'h0f, 1, 0, 0);
    step(1, 1, 8'h07, 8'h0f, 1, 0, 0);
    step(1, 1, 8'h0c, 8'h0f, 1, 0, 0);
    check_value("tp3_full", 32'(a_full), 32'h1);
    step(1, 0, 8'h00, 8'h00, 1, 0, 0);
    check_value("tp3_ovf", 32'(a_ovf), 32'h1);
    check_value("tp3_top_kept", 32'(a_top), 32'h7);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 8'h00, 8'h00, 0, 1, 0);
      check_value("tp3_lifo", 32'(a_flag), 32'(pops[i]));
    end
    step(1, 0, 8'h00, 8'h00, 0, 1, 0);
    check_value("tp3_unf", 32'(a_unf), 32'h1);
    check_value("tp3_flag_kept", 32'(a_flag), 32'h9);

    // Exchange
    step(1, 1, 8'h03, 8'h0f, 0, 0, 1);
    step(1, 1, 8'h0c, 8'h0f, 1, 0, 0);
    step(1, 1, 8'h01, 8'h0f, 1, 1, 0);
    check_value("tp4_xchg_flag", 32'(a_flag), 32'h3);
    check_value("tp4_xchg_top", 32'(a_top), 32'hc);
    check_value("tp4_xchg_cnt", 32'(a_count), 32'h1);
    step(1, 0, 8'h00, 8'h00, 0, 1, 0);
    step(1, 0, 8'h00, 8'h00, 1, 1, 0);
    check_value("tp4_xchg_unf", 32'(a_unf), 32'h1);
    check_value("tp4_xchg_nochg", 32'(a_flag), 32'hc);

    // Run gating and error clearing
    step(0, 1, 8'hff, 8'hff, 1, 1, 1);
    check_value("tp5_frozen_unf", 32'(a_unf), 32'h1);
    for (int i = 0; i < 4; i++) step(1, 1, 8'(i + 1), 8'h0f, 1, 0, 0);
    step(1, 0, 8'h00, 8'h00, 1, 0, 1);
    check_value("tp5_ovf_wins", 32'(a_ovf), 32'h1);
    check_value("tp5_unf_clr", 32'(a_unf), 32'h0);
    step(1, 0, 8'h00, 8'h00, 0, 0, 1);
    check_value("tp5_ovf_clr", 32'(a_ovf), 32'h0);

    // Asynchronous reset mid-cycle
    step(1, 1, 8'hff, 8'hff, 0, 1, 0);
    check_value("tp6_pre_cnt", 32'(a_count), 32'h3);
    async_reset();
    check_value("tp6_cnt", 32'(a_count), 32'h0);
    check_value("tp6_empty", 32'(a_empty), 32'h1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        async_reset();
      end else begin
        step(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
             8'($urandom), 8'($urandom),
             1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
             1'($urandom_range(0, 9) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
